// File: rtl/img_lut_csr_pkg.sv
// Register indices of the LUT CSR block (word offsets; byte address = index << 2).
package img_lut_csr_pkg;

  localparam logic [31:0] LUT_ORIG_PX_CR = 32'd1;
  localparam logic [31:0] LUT_MOD_PX_CR  = 32'd2;
  localparam logic [31:0] LUT_WR_STB_CR  = 32'd3;

endpackage

// File: rtl/img_lut_loader_pkg.sv
// Types for img_lut_loader. RD_MOD exists only when IMG_LUT_LOADER_VERIFY_EN is defined.
package img_lut_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WR_ORIG,
    WR_MOD,
`ifdef IMG_LUT_LOADER_VERIFY_EN
    RD_MOD,
`endif
    WR_STB_SET,
    WR_STB_CLR,
    DONE
  } state_e;

endpackage

// File: rtl/axi4_lite_if.sv
// 32-bit AXI4-Lite bundle with initiator (master) and target (slave) views.
interface axi4_lite_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_single_wr.sv
// One AXI4-Lite write per req level: aw and w retire independently, done pulses on the b handshake.
module axi4_lite_single_wr (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        done,
  output logic [1:0]  resp,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp
);

  logic aw_sent_q;
  logic w_sent_q;

  // Valids are combinational from req so they rise in the requester's state-entry cycle.
  assign awvalid = req & ~aw_sent_q;
  assign wvalid  = req & ~w_sent_q;
  assign awaddr  = addr;
  assign wdata   = data;
  assign wstrb   = {4{req}};
  assign bready  = req;
  assign done    = req & bvalid;
  assign resp    = bresp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
    end else if (done) begin
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
    end else begin
      if (awvalid && awready) aw_sent_q <= 1'b1;
      if (wvalid && wready)   w_sent_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/img_lut_loader.sv
// AXI4-Lite initiator that streams a full image LUT into the LUT CSR block, one entry per source beat.
// Define IMG_LUT_LOADER_VERIFY_EN to read back and compare each MOD_PX write.
module img_lut_loader
  import img_lut_loader_pkg::*;
  import img_lut_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned PX_WIDTH  = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [PX_WIDTH-1:0] lut_data_i,
  input  logic                lut_valid_i,
  output logic                lut_ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  axi4_lite_if.master         csr_o
);

  localparam logic [31:0]         ORIG_ADDR = BASE_ADDR + (LUT_ORIG_PX_CR << 2);
  localparam logic [31:0]         MOD_ADDR  = BASE_ADDR + (LUT_MOD_PX_CR << 2);
  localparam logic [31:0]         STB_ADDR  = BASE_ADDR + (LUT_WR_STB_CR << 2);
  localparam logic [PX_WIDTH-1:0] LAST_IDX  = '1;

  state_e              state_q, state_d;
  logic [PX_WIDTH-1:0] cnt_q;
  logic [PX_WIDTH-1:0] mod_q;
  logic                err_q;

  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_done;
  logic [1:0]  wr_resp;

  logic        awvalid, wvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;

  axi4_lite_single_wr u_wr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (wr_req),
    .addr    (wr_addr),
    .data    (wr_data),
    .done    (wr_done),
    .resp    (wr_resp),
    .awvalid (awvalid),
    .awready (csr_o.awready),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wready  (csr_o.wready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .bvalid  (csr_o.bvalid),
    .bready  (bready),
    .bresp   (csr_o.bresp)
  );

  assign csr_o.awvalid = awvalid;
  assign csr_o.awaddr  = awaddr;
  assign csr_o.wvalid  = wvalid;
  assign csr_o.wdata   = wdata;
  assign csr_o.wstrb   = wstrb;
  assign csr_o.bready  = bready;

`ifdef IMG_LUT_LOADER_VERIFY_EN
  logic ar_sent_q;
  logic rd_active;
  logic rd_done;

  assign rd_active     = (state_q == RD_MOD);
  assign csr_o.arvalid = rd_active & ~ar_sent_q;
  assign csr_o.araddr  = rd_active ? MOD_ADDR : '0;
  assign csr_o.rready  = rd_active;
  assign rd_done       = rd_active & csr_o.rvalid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                ar_sent_q <= 1'b0;
    else if (rd_done)                         ar_sent_q <= 1'b0;
    else if (csr_o.arvalid && csr_o.arready)  ar_sent_q <= 1'b1;
  end
`else
  assign csr_o.arvalid = 1'b0;
  assign csr_o.araddr  = '0;
  assign csr_o.rready  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state_q)
      IDLE:  if (start_i) state_d = FETCH;
      FETCH: if (lut_valid_i) state_d = WR_ORIG;
      WR_ORIG: begin
        wr_req  = 1'b1;
        wr_addr = ORIG_ADDR;
        wr_data = 32'(cnt_q);
        if (wr_done) state_d = WR_MOD;
      end
      WR_MOD: begin
        wr_req  = 1'b1;
        wr_addr = MOD_ADDR;
        wr_data = 32'(mod_q);
`ifdef IMG_LUT_LOADER_VERIFY_EN
        if (wr_done) state_d = RD_MOD;
`else
        if (wr_done) state_d = WR_STB_SET;
`endif
      end
`ifdef IMG_LUT_LOADER_VERIFY_EN
      RD_MOD: if (rd_done) state_d = WR_STB_SET;
`endif
      WR_STB_SET: begin
        wr_req  = 1'b1;
        wr_addr = STB_ADDR;
        wr_data = 32'd1;
        if (wr_done) state_d = WR_STB_CLR;
      end
      WR_STB_CLR: begin
        wr_req  = 1'b1;
        wr_addr = STB_ADDR;
        wr_data = 32'd0;
        if (wr_done) state_d = (cnt_q == LAST_IDX) ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mod_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end
      if (state_q == FETCH && lut_valid_i) mod_q <= lut_data_i;
      if (state_q == WR_STB_CLR && wr_done && cnt_q != LAST_IDX) cnt_q <= cnt_q + 1'b1;
      if (wr_done && wr_resp != 2'b00) err_q <= 1'b1;
`ifdef IMG_LUT_LOADER_VERIFY_EN
      if (rd_done && (csr_o.rresp != 2'b00 || csr_o.rdata[PX_WIDTH-1:0] != mod_q)) err_q <= 1'b1;
`endif
    end
  end

  assign lut_ready_o = (state_q == FETCH);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_img_lut_loader.sv
// Bench for img_lut_loader (PX_WIDTH=2): scoreboarded AXI4-Lite LUT CSR slave and pixel source.
// Define IMG_LUT_LOADER_VERIFY_EN for both RTL and bench to cover the read-back path.
module tb_img_lut_loader;
  import img_lut_csr_pkg::*;

  localparam int unsigned PXW   = 2;
  localparam int unsigned DEPTH = 1 << PXW;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam logic [31:0] A_ORIG = BASE + LUT_ORIG_PX_CR * 32'd4;
  localparam logic [31:0] A_MOD  = BASE + LUT_MOD_PX_CR * 32'd4;
  localparam logic [31:0] A_STB  = BASE + LUT_WR_STB_CR * 32'd4;
`ifdef IMG_LUT_LOADER_VERIFY_EN
  localparam int unsigned RD_PER_LOAD   = DEPTH;
  localparam int unsigned CYC_PER_ENTRY = 16;
`else
  localparam int unsigned RD_PER_LOAD   = 0;
  localparam int unsigned CYC_PER_ENTRY = 13;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [PXW-1:0] lut_data = '0;
  logic           lut_valid = 1'b0;
  logic           lut_ready, busy, done, err;

  axi4_lite_if csr ();

  always #5 clk = ~clk;

  img_lut_loader #(.BASE_ADDR(BASE), .PX_WIDTH(PXW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .lut_data_i  (lut_data),
    .lut_valid_i (lut_valid),
    .lut_ready_o (lut_ready),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .csr_o       (csr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected writes {addr,data} and expected strobe pairs (orig<<8 | mod).
  logic [63:0] exp_wr_q[$];
  logic [31:0] exp_stb_q[$];
  int src_q[$];
  int src_hold = 0;
  int tb_idx = 0;
  int done_cnt = 0, stb_cnt = 0, wr_cnt = 0, rd_cnt = 0, busy_cyc = 0;

  // Slave configuration and state.
  int cfg_aw_dly = 0, cfg_w_dly = 0, err_at_wr = -1, wr_idx = 0;
  bit corrupt_rd = 1'b0;
  int aw_wait = 1, w_wait = 1, ar_wait = 1;
  bit aw_have = 0, w_have = 0, b_acc = 0, ar_have = 0, r_acc = 0;
  logic [31:0] aw_a, w_d;
  logic [31:0] reg_orig = '0, reg_mod = '0, reg_stb = '0;

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    logic [63:0] e;
    logic [31:0] s;
    wr_cnt++;
    check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
    if (exp_wr_q.size() != 0) begin
      e = exp_wr_q.pop_front();
      check("wr_addr", a, e[63:32]);
      check("wr_data", d, e[31:0]);
    end
    if (a == A_ORIG) reg_orig = d;
    else if (a == A_MOD) reg_mod = d;
    else if (a == A_STB) begin
      if (d[0] && !reg_stb[0]) begin
        stb_cnt++;
        check("stb_expected", 32'(exp_stb_q.size() != 0), 32'd1);
        if (exp_stb_q.size() != 0) begin
          s = exp_stb_q.pop_front();
          check("stb_pair", (reg_orig << 8) | reg_mod, s);
        end
      end
      reg_stb = d;
    end
  endtask

  // Pixel source: models drive at negedge; a handshake lands on the following posedge.
  always @(negedge clk) begin : src_model
    int v;
    if (rst) begin
      lut_valid = 1'b0;
      lut_data  = '0;
    end else begin
      if (src_hold > 0) begin
        lut_valid = 1'b0;
        src_hold--;
        if (lut_ready) check("stall_axi_idle", {29'd0, csr.awvalid, csr.wvalid, csr.arvalid}, 32'd0);
      end else begin
        lut_valid = (src_q.size() != 0);
        if (lut_valid) lut_data = PXW'(src_q[0]);
      end
      if (lut_valid && lut_ready) begin
        v = src_q.pop_front();
        exp_wr_q.push_back({A_ORIG, 32'(tb_idx)});
        exp_wr_q.push_back({A_MOD, 32'(v)});
        exp_wr_q.push_back({A_STB, 32'd1});
        exp_wr_q.push_back({A_STB, 32'd0});
        exp_stb_q.push_back((32'(tb_idx) << 8) | 32'(v));
        tb_idx++;
      end
    end
  end

  // LUT CSR slave: readiness is seen one cycle after valid (registered-ready slave).
  always @(negedge clk) begin : slave_model
    if (rst) begin
      csr.awready = 1'b0; csr.wready = 1'b0; csr.bvalid = 1'b0; csr.bresp = 2'b00;
      csr.arready = 1'b0; csr.rvalid = 1'b0; csr.rdata = '0; csr.rresp = 2'b00;
      aw_have = 0; w_have = 0; b_acc = 0; ar_have = 0; r_acc = 0;
      aw_wait = cfg_aw_dly + 1; w_wait = cfg_w_dly + 1; ar_wait = 1;
    end else begin
      if (b_acc) begin csr.bvalid = 1'b0; b_acc = 0; end
      if (aw_have && w_have && !csr.bvalid) begin
        do_write(aw_a, w_d);
        csr.bvalid = 1'b1;
        csr.bresp  = (wr_idx == err_at_wr) ? 2'b10 : 2'b00;
        wr_idx++;
        aw_have = 0; w_have = 0;
      end
      if (csr.bvalid && csr.bready) b_acc = 1;

      if (aw_have) begin
        check("aw_dup", {31'd0, csr.awvalid}, 32'd0);
        csr.awready = 1'b0;
      end else if (csr.awvalid) begin
        if (aw_wait > 0) begin aw_wait--; csr.awready = 1'b0; end
        else csr.awready = 1'b1;
      end else begin
        csr.awready = 1'b0;
        aw_wait = cfg_aw_dly + 1;
      end
      if (csr.awvalid && csr.awready) begin aw_have = 1; aw_a = csr.awaddr; aw_wait = cfg_aw_dly + 1; end

      if (w_have) begin
        check("w_dup", {31'd0, csr.wvalid}, 32'd0);
        csr.wready = 1'b0;
      end else if (csr.wvalid) begin
        if (w_wait > 0) begin w_wait--; csr.wready = 1'b0; end
        else csr.wready = 1'b1;
      end else begin
        csr.wready = 1'b0;
        w_wait = cfg_w_dly + 1;
      end
      if (csr.wvalid && csr.wready) begin
        w_have = 1; w_d = csr.wdata; w_wait = cfg_w_dly + 1;
        check("wstrb", {28'd0, csr.wstrb}, 32'hF);
      end

      if (r_acc) begin csr.rvalid = 1'b0; r_acc = 0; end
      if (ar_have && !csr.rvalid) begin
        csr.rvalid = 1'b1;
        csr.rdata  = corrupt_rd ? (reg_mod ^ 32'h2) : reg_mod;
        csr.rresp  = 2'b00;
        ar_have = 0;
        rd_cnt++;
      end
      if (csr.rvalid && csr.rready) r_acc = 1;
      if (!ar_have && csr.arvalid) begin
        if (ar_wait > 0) begin ar_wait--; csr.arready = 1'b0; end
        else csr.arready = 1'b1;
      end else begin
        csr.arready = 1'b0;
        ar_wait = 1;
      end
      if (csr.arvalid && csr.arready) begin
        ar_have = 1; ar_wait = 1;
        check("rd_addr", csr.araddr, A_MOD);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (busy && !done) busy_cyc++;
    end
  end

  task automatic check_reset(input string p);
    check({p, "_busy"}, {31'd0, busy}, 32'd0);
    check({p, "_done"}, {31'd0, done}, 32'd0);
    check({p, "_err"}, {31'd0, err}, 32'd0);
    check({p, "_lut_ready"}, {31'd0, lut_ready}, 32'd0);
    check({p, "_awvalid"}, {31'd0, csr.awvalid}, 32'd0);
    check({p, "_wvalid"}, {31'd0, csr.wvalid}, 32'd0);
    check({p, "_bready"}, {31'd0, csr.bready}, 32'd0);
    check({p, "_arvalid"}, {31'd0, csr.arvalid}, 32'd0);
    check({p, "_rready"}, {31'd0, csr.rready}, 32'd0);
    check({p, "_awaddr"}, csr.awaddr, 32'd0);
    check({p, "_wdata"}, csr.wdata, 32'd0);
    check({p, "_wstrb"}, {28'd0, csr.wstrb}, 32'd0);
    check({p, "_araddr"}, csr.araddr, 32'd0);
  endtask

  task automatic push_table(input bit descending);
    for (int unsigned i = 0; i < DEPTH; i++)
      src_q.push_back(descending ? int'(DEPTH - 1 - i) : int'($urandom_range(0, DEPTH - 1)));
  endtask

  task automatic clr_stats();
    done_cnt = 0; stb_cnt = 0; wr_cnt = 0; rd_cnt = 0; busy_cyc = 0;
  endtask

  task automatic start_load();
    @(posedge clk); #1;
    if (!busy) begin tb_idx = 0; wr_idx = 0; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
  endtask

  task automatic end_load(input string tag, input logic exp_err);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_writes"}, wr_cnt, 4 * DEPTH);
    check({tag, "_strobes"}, stb_cnt, DEPTH);
    check({tag, "_reads"}, rd_cnt, RD_PER_LOAD);
    check({tag, "_wr_q_empty"}, exp_wr_q.size(), 0);
    check({tag, "_stb_q_empty"}, exp_stb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1 rst = 1'b0;

    // Descending table, zero-wait slave, plus per-entry cycle cost.
    clr_stats(); push_table(1'b1);
    repeat (2) @(posedge clk);
    start_load(); wait_done("t1", 400);
    end_load("t1", 1'b0);
    check("t1_cycles", busy_cyc, CYC_PER_ENTRY * DEPTH);

    // AW ready lags W, then the reverse.
    cfg_aw_dly = 3; cfg_w_dly = 0;
    clr_stats(); push_table(1'b0); start_load(); wait_done("t2a", 600); end_load("t2a", 1'b0);
    cfg_aw_dly = 0; cfg_w_dly = 3;
    clr_stats(); push_table(1'b0); start_load(); wait_done("t2b", 600); end_load("t2b", 1'b0);
    cfg_w_dly = 0;

    // Source stalls 20 cycles with the FSM parked in FETCH.
    clr_stats();
    src_q.push_back(1); src_q.push_back(3);
    start_load();
    begin
      int n = 0;
      while (!(src_q.size() == 0 && lut_ready) && n < 200) begin @(posedge clk); #1; n++; end
    end
    check("t3_in_fetch", {31'd0, lut_ready}, 32'd1);
    src_hold = 20;
    src_q.push_back(0); src_q.push_back(2);
    wait_done("t3", 600); end_load("t3", 1'b0);

    // SLVERR on entry 1 MOD_PX write; sticky until next accepted start.
    clr_stats(); err_at_wr = 5; push_table(1'b0);
    start_load(); wait_done("t4", 400); end_load("t4", 1'b1);
    repeat (5) @(posedge clk); #1;
    check("t4_err_sticky", {31'd0, err}, 32'd1);
    err_at_wr = -1;
    clr_stats(); push_table(1'b0); start_load();
    check("t4_err_cleared", {31'd0, err}, 32'd0);
    wait_done("t4b", 400); end_load("t4b", 1'b0);

    // start_i while busy is ignored.
    clr_stats(); push_table(1'b0); start_load();
    begin
      int n = 0;
      while (tb_idx < 2 && n < 200) begin @(posedge clk); #1; n++; end
    end
    check("t5_busy_at_restart", {31'd0, busy}, 32'd1);
    start_load();
    wait_done("t5", 400); end_load("t5", 1'b0);

    // Reset during WR_MOD, then a full reload from entry 0.
    clr_stats(); push_table(1'b0); start_load();
    begin
      int n = 0;
      while (!(csr.awvalid && csr.awaddr == A_MOD) && n < 200) begin @(negedge clk); n++; end
    end
    check("t6_saw_wr_mod", csr.awaddr, A_MOD);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_wr_q.delete(); exp_stb_q.delete(); src_q.delete(); src_hold = 0;
    @(negedge clk);
    check_reset("t6_midrst");
    @(posedge clk); #1 rst = 1'b0;
    clr_stats(); push_table(1'b0); start_load(); wait_done("t6", 400); end_load("t6", 1'b0);

`ifdef IMG_LUT_LOADER_VERIFY_EN
    // Corrupted MOD_PX readback flags err_o but the load still completes.
    corrupt_rd = 1'b1;
    clr_stats(); push_table(1'b0); start_load(); wait_done("t7", 400); end_load("t7", 1'b1);
    corrupt_rd = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
